// File: rtl/note_sequencer.sv
// Music-box note sequencer: walks a note ROM address through a song, timing each note as
// (rom_dur+1)*TICK_DIV clocks, with play/pause/stop control, optional looping and end strobe.
module note_sequencer #(
   parameter int TICK_DIV = 6000000,
   parameter int ADDR_W   = 5,
   parameter int SONG_LEN = 25,
   parameter int DUR_W    = 3,
   parameter int CNT_W    = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_play,
   input  logic              cmd_pause,
   input  logic              cmd_stop,
   input  logic              loop_en,
   input  logic [DUR_W-1:0]  rom_dur,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              note_start,
   output logic              playing,
   output logic              paused,
   output logic              done,
   output logic [CNT_W-1:0]  tick_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [CNT_W-1:0]    tick_reg, tick_next;
   logic [DUR_W-1:0]    unit_reg, unit_next;
   logic                note_start_reg, note_start_next;
   logic                playing_reg, playing_next;
   logic                paused_reg, paused_next;
   logic                done_reg, done_next;
   logic                note_end;
   logic                last_note;

   assign note_end  = (tick_reg == TICK_LAST) && (unit_reg == rom_dur);
   assign last_note = (addr_reg == ADDR_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         addr_reg       <= '0;
         tick_reg       <= '0;
         unit_reg       <= '0;
         note_start_reg <= 1'b0;
         playing_reg    <= 1'b0;
         paused_reg     <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         tick_reg       <= tick_next;
         unit_reg       <= unit_next;
         note_start_reg <= note_start_next;
         playing_reg    <= playing_next;
         paused_reg     <= paused_next;
         done_reg       <= done_next;
      end
   end

   // cmd_play while already playing is a no-op that still outranks a simultaneous pause
   always_comb begin
      state_next = state_reg;
      if (cmd_stop) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE:  if (cmd_play) state_next = S_PLAY;
            S_PLAY: begin
               if (cmd_pause && !cmd_play)
                  state_next = S_PAUSE;
               else if (note_end && last_note && !loop_en)
                  state_next = S_IDLE;
            end
            S_PAUSE: if (cmd_play) state_next = S_PLAY;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      addr_next       = addr_reg;
      tick_next       = tick_reg;
      unit_next       = unit_reg;
      note_start_next = 1'b0;
      done_next       = 1'b0;
      playing_next    = (state_next == S_PLAY);
      paused_next     = (state_next == S_PAUSE);
      if (state_next == S_IDLE) begin
         addr_next = '0;
         tick_next = '0;
         unit_next = '0;
         done_next = (state_reg == S_PLAY) && !cmd_stop;
      end else if (state_reg == S_IDLE) begin
         addr_next       = '0;
         tick_next       = '0;
         unit_next       = '0;
         note_start_next = 1'b1;
      end else if (state_reg == S_PLAY && state_next == S_PLAY) begin
         if (note_end) begin
            tick_next       = '0;
            unit_next       = '0;
            note_start_next = 1'b1;
            addr_next       = last_note ? '0 : addr_reg + ADDR_W'(1);
         end else if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            unit_next = unit_reg + DUR_W'(1);
         end else begin
            tick_next = tick_reg + CNT_W'(1);
         end
      end
   end

   assign rom_addr   = addr_reg;
   assign tick_cnt   = tick_reg;
   assign note_start = note_start_reg;
   assign playing    = playing_reg;
   assign paused     = paused_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios then random commands, all checked every cycle
// against a note-index/elapsed-cycles model of the song.
module tb_note_sequencer;
   localparam int TICK_DIV = 4;
   localparam int ADDR_W   = 2;
   localparam int SONG_LEN = 3;
   localparam int DUR_W    = 3;
   localparam int CNT_W    = 3;

   logic              clk = 1'b0;
   logic              rst, cmd_play, cmd_pause, cmd_stop, loop_en;
   logic [DUR_W-1:0]  rom_dur;
   logic [ADDR_W-1:0] rom_addr;
   logic              note_start, playing, paused, done;
   logic [CNT_W-1:0]  tick_cnt;

   always #5 clk = ~clk;

   note_sequencer #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN),
                    .DUR_W(DUR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd_play(cmd_play), .cmd_pause(cmd_pause),
      .cmd_stop(cmd_stop), .loop_en(loop_en), .rom_dur(rom_dur), .rom_addr(rom_addr),
      .note_start(note_start), .playing(playing), .paused(paused), .done(done),
      .tick_cnt(tick_cnt));

   always_comb begin
      case (rom_addr)
         2'd0:    rom_dur = 3'd0;
         2'd1:    rom_dur = 3'd1;
         2'd2:    rom_dur = 3'd2;
         default: rom_dur = 3'd0;
      endcase
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int durs[3] = '{0, 1, 2};
   int m_state = 0;   // 0 idle, 1 play, 2 pause
   int m_idx = 0;
   int m_el = 0;      // cycles elapsed within the current note
   bit m_ns = 0;
   bit m_done = 0;
   int act[4];
   int ns_log[$];
   int done_log[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int len;
      m_ns = 0;
      m_done = 0;
      if (rst) begin
         m_state = 0; m_idx = 0; m_el = 0;
      end else begin
         case (m_state)
            0: if (!cmd_stop && cmd_play) begin
                  m_state = 1; m_idx = 0; m_el = 0; m_ns = 1;
               end
            1: if (cmd_stop) begin
                  m_state = 0; m_idx = 0; m_el = 0;
               end else if (cmd_pause && !cmd_play) begin
                  m_state = 2;
               end else begin
                  len = (durs[m_idx] + 1) * TICK_DIV;
                  if (m_el == len - 1) begin
                     m_el = 0;
                     if (m_idx < SONG_LEN - 1) begin
                        m_idx++; m_ns = 1;
                     end else if (loop_en) begin
                        m_idx = 0; m_ns = 1;
                     end else begin
                        m_idx = 0; m_state = 0; m_done = 1;
                     end
                  end else begin
                     m_el++;
                  end
               end
            default: if (cmd_stop) begin
                  m_state = 0; m_idx = 0; m_el = 0;
               end else if (cmd_play) begin
                  m_state = 1;
               end
         endcase
      end
   endtask

   task automatic cycle();
      // a cycle counts toward a note's length only if its tick is actually consumed
      if (playing && !cmd_pause && !cmd_stop && !rst) act[rom_addr]++;
      if (rst || cmd_play || cmd_pause || cmd_stop)
         $display("cyc %0d rst=%0b play=%0b pause=%0b stop=%0b loop=%0b addr=%0d tick=%0d",
                  cyc, rst, cmd_play, cmd_pause, cmd_stop, loop_en, rom_addr, tick_cnt);
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk("addr", rom_addr, m_idx);
      chk("tick", tick_cnt, m_el % TICK_DIV);
      chk("note_start", note_start, m_ns);
      chk("playing", playing, m_state == 1);
      chk("paused", paused, m_state == 2);
      chk("done", done, m_done);
      if (note_start) ns_log.push_back(cyc);
      if (done) done_log.push_back(cyc);
      cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
   endtask

   task automatic wait_until(input int a, input int t, input string tag);
      int n = 0;
      while (!(rom_addr == a && tick_cnt == t) && n < 200) begin
         cycle();
         n++;
      end
      chk(tag, n < 200, 1);
   endtask

   task automatic clear_logs();
      ns_log.delete();
      done_log.delete();
      for (int i = 0; i < 4; i++) act[i] = 0;
      cyc = 0;
   endtask

   int e1[3] = '{1, 5, 13};
   int e2[7] = '{1, 5, 13, 25, 29, 37, 49};
   int ea[3] = '{4, 8, 12};
   int r;

   initial begin
      rst = 1; cmd_play = 0; cmd_pause = 0; cmd_stop = 0; loop_en = 0;
      for (int i = 0; i < 4; i++) act[i] = 0;
      #2;
      cycle(); cycle();
      chk("rst_addr", rom_addr, 0);
      chk("rst_tick", tick_cnt, 0);
      chk("rst_flags", {note_start, playing, paused, done}, 0);
      rst = 0;

      // one full song, no loop
      clear_logs();
      cmd_play = 1; cycle();
      repeat (30) cycle();
      chk("t1_ns_count", ns_log.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("t1_ns_cycle", (i < ns_log.size()) ? ns_log[i] : -1, e1[i]);
      chk("t1_done_count", done_log.size(), 1);
      chk("t1_done_cycle", (done_log.size() > 0) ? done_log[0] : -1, 25);
      for (int i = 0; i < 3; i++) chk("t1_note_len", act[i], ea[i]);
      chk("t1_idle_playing", playing, 0);
      chk("t1_idle_addr", rom_addr, 0);

      // looping: second pass identical
      loop_en = 1;
      clear_logs();
      cmd_play = 1; cycle();
      repeat (48) cycle();
      chk("t2_ns_count", ns_log.size(), 7);
      for (int i = 0; i < 7; i++)
         chk("t2_ns_cycle", (i < ns_log.size()) ? ns_log[i] : -1, e2[i]);
      chk("t2_no_done", done_log.size(), 0);
      cmd_stop = 1; cycle();
      chk("t4_stop_play", {playing, paused, done}, 0);
      chk("t4_stop_play_addr", rom_addr, 0);
      loop_en = 0;

      // pause mid-note, resume without note_start, note length preserved
      clear_logs();
      cmd_play = 1; cycle();
      wait_until(1, 2, "t3_reach");
      for (int i = 0; i < 4; i++) act[i] = 0;
      act[1] = 2;
      cmd_pause = 1; cycle();
      chk("t3_paused", paused, 1);
      chk("t3_frozen_tick", tick_cnt, 2);
      repeat (10) cycle();
      chk("t3_hold_tick", tick_cnt, 2);
      chk("t3_hold_addr", rom_addr, 1);
      cmd_play = 1; cycle();
      chk("t3_resume_tick", tick_cnt, 2);
      chk("t3_resume_ns", note_start, 0);
      wait_until(2, 0, "t3_reach2");
      chk("t3_note1_len", act[1], 8);
      cmd_pause = 1; cycle();
      cmd_stop = 1; cycle();
      chk("t4_stop_pause", {playing, paused, done}, 0);
      chk("t4_stop_pause_tick", tick_cnt, 0);

      // command priority and pause on a note-end cycle
      cmd_play = 1; cycle();
      repeat (2) cycle();
      cmd_stop = 1; cmd_play = 1; cycle();
      chk("t5_stop_wins", playing, 0);
      cmd_play = 1; cmd_pause = 1; cycle();
      chk("t5_play_wins", {playing, paused, note_start}, 3'b101);
      wait_until(0, 3, "t5_reach");
      cmd_pause = 1; cycle();
      chk("t5_end_pause", {paused, note_start, rom_addr}, {1'b1, 1'b0, 2'd0});
      cmd_play = 1; cycle();
      chk("t5_end_resume_tick", tick_cnt, 3);
      cycle();
      chk("t5_end_advance", {note_start, rom_addr}, {1'b1, 2'd1});

      // reset mid-song
      wait_until(2, 1, "t6_reach");
      rst = 1; cycle(); rst = 0;
      chk("t6_rst_outputs", {rom_addr, tick_cnt, note_start, playing, paused, done}, 0);
      cmd_play = 1; cycle();
      chk("t6_restart", {note_start, rom_addr}, {1'b1, 2'd0});

      // random commands against the model
      for (int k = 0; k < 800; k++) begin
         r = $urandom_range(0, 99);
         if (r < 4) cmd_play = 1;
         else if (r < 7) cmd_pause = 1;
         else if (r < 9) cmd_stop = 1;
         else if (r == 9) begin cmd_stop = 1; cmd_play = 1; end
         else if (r == 10) begin cmd_stop = 1; cmd_pause = 1; end
         else if (r == 11) rst = 1;
         if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
         cycle();
         rst = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
